// File: rtl/gpu_result_accumulator.sv
// Accumulates the GPU datapath result stream into per-lane dot-product sums of a programmable
// length and queues each completed sum in a small valid/ready output FIFO.
module gpu_result_accumulator #(
  parameter int LEN_W   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [LEN_W-1:0]   vec_len,
  input  logic               in_valid,
  input  logic [63:0]        in_result,
  input  logic               in_zero_skipped,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [63:0]        out_sum,
  output logic [LEN_W:0]     out_skip_cnt,
  output logic               overflow,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level
);

  // state   | meaning
  // ST_IDLE | in_valid ignored, waiting for start
  // ST_RUN  | accumulating elements into the current vector
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [LEN_W:0]   CNT_ONE   = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]   LEN_MAX   = {1'b1, {LEN_W{1'b0}}};
  localparam logic [FIFO_AW:0] LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [63:0]        acc_q, acc_d;
  logic [LEN_W:0]     elem_cnt_q, elem_cnt_d;
  logic [LEN_W:0]     skip_cnt_q, skip_cnt_d;

  // Completed vector held for one cycle before it is written into the FIFO.
  logic               stg_vld_q, stg_vld_d;
  logic [63:0]        stg_sum_q, stg_sum_d;
  logic [LEN_W:0]     stg_skip_q, stg_skip_d;

  logic [63:0]        sum_next;
  logic [LEN_W:0]     skip_next;
  logic [LEN_W:0]     cnt_next;
  logic [LEN_W:0]     len_eff;
  logic               elem;
  logic               add_en;
  logic               done;

  logic [63:0]        mem_sum  [DEPTH];
  logic [LEN_W:0]     mem_skip [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               push, pop, full, drop;

  assign elem    = (state_q == ST_RUN) && in_valid && !start;
  assign add_en  = !in_zero_skipped && (mode_q != 2'b11);
  assign len_eff = (len_q == '0) ? LEN_MAX : {1'b0, len_q};

  // Lane-wise addition; each lane wraps on its own so no carry crosses a lane boundary.
  always_comb begin
    sum_next = acc_q;
    if (add_en) begin
      case (mode_q)
        2'b00: begin
          for (int k = 0; k < 4; k++) begin
            sum_next[16*k +: 16] = acc_q[16*k +: 16] + in_result[16*k +: 16];
          end
        end
        2'b01: begin
          sum_next[31:0]  = acc_q[31:0]  + {16'b0, in_result[15:0]};
          sum_next[63:32] = acc_q[63:32] + {16'b0, in_result[31:16]};
        end
        2'b10:   sum_next = acc_q + {32'b0, in_result[31:0]};
        default: sum_next = acc_q;
      endcase
    end
  end

  assign skip_next = skip_cnt_q + (in_zero_skipped ? CNT_ONE : '0);
  assign cnt_next  = elem_cnt_q + CNT_ONE;
  assign done      = elem && (cnt_next == len_eff);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    acc_d      = acc_q;
    elem_cnt_d = elem_cnt_q;
    skip_cnt_d = skip_cnt_q;
    stg_vld_d  = 1'b0;
    stg_sum_d  = stg_sum_q;
    stg_skip_d = stg_skip_q;

    if (start) begin
      state_d    = ST_RUN;
      mode_d     = mode;
      len_d      = vec_len;
      acc_d      = '0;
      elem_cnt_d = '0;
      skip_cnt_d = '0;
    end else begin
      if (elem) begin
        if (done) begin
          stg_vld_d  = 1'b1;
          stg_sum_d  = sum_next;
          stg_skip_d = skip_next;
          acc_d      = '0;
          elem_cnt_d = '0;
          skip_cnt_d = '0;
        end else begin
          acc_d      = sum_next;
          elem_cnt_d = cnt_next;
          skip_cnt_d = skip_next;
        end
      end
      if ((state_q == ST_RUN) && stop) begin
        state_d    = ST_IDLE;
        acc_d      = '0;
        elem_cnt_d = '0;
        skip_cnt_d = '0;
      end
    end
  end

  assign full = (level_q == LVL_FULL);
  assign pop  = (level_q != '0) && out_ready;
  assign push = stg_vld_q && (!full || pop);
  assign drop = stg_vld_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = start ? 1'b0 : ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      elem_cnt_q <= '0;
      skip_cnt_q <= '0;
      stg_vld_q  <= 1'b0;
      stg_sum_q  <= '0;
      stg_skip_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      elem_cnt_q <= elem_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      stg_vld_q  <= stg_vld_d;
      stg_sum_q  <= stg_sum_d;
      stg_skip_q <= stg_skip_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[wr_ptr_q]  <= stg_sum_q;
      mem_skip[wr_ptr_q] <= stg_skip_q;
    end
  end

  assign out_valid    = (level_q != '0);
  assign out_sum      = out_valid ? mem_sum[rd_ptr_q]  : '0;
  assign out_skip_cnt = out_valid ? mem_skip[rd_ptr_q] : '0;
  assign overflow     = ovf_q;
  assign busy         = (state_q == ST_RUN);
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_gpu_result_accumulator.sv
// Directed bench for gpu_result_accumulator: a queue-based reference model is compared on every
// falling edge, plus literal expectations from hand-worked vectors.
module tb_gpu_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  vec_len = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_result = '0;
  logic        in_zero_skipped = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_sum;
  logic [8:0]  out_skip_cnt;
  logic        overflow;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  gpu_result_accumulator #(.LEN_W(8), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .vec_len(vec_len),
    .in_valid(in_valid), .in_result(in_result), .in_zero_skipped(in_zero_skipped),
    .out_ready(out_ready), .out_valid(out_valid), .out_sum(out_sum),
    .out_skip_cnt(out_skip_cnt), .overflow(overflow), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [63:0] sum; int skip; } ent_t;
  ent_t              q[$];
  ent_t              pend_e, new_e;
  bit                pend, m_busy, m_ovf, m_pop;
  int                m_mode, m_len, m_cnt, m_skip, nl, lw;
  longint unsigned   lane[4];
  longint unsigned   a, smask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pend = 0; m_busy = 0; m_ovf = 0;
      m_mode = 0; m_len = 256; m_cnt = 0; m_skip = 0;
      for (int k = 0; k < 4; k++) lane[k] = 0;
    end else begin
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (start) m_ovf = 0;
      if (pend) begin
        if (q.size() < 4) q.push_back(pend_e);
        else m_ovf = 1;
        pend = 0;
      end
      if (start) begin
        m_busy = 1;
        m_mode = int'(mode);
        m_len  = (vec_len == 0) ? 256 : int'(vec_len);
        m_cnt = 0; m_skip = 0;
        for (int k = 0; k < 4; k++) lane[k] = 0;
      end else if (m_busy) begin
        if (in_valid) begin
          nl    = (m_mode == 0) ? 4 : (m_mode == 1) ? 2 : 1;
          lw    = 64 / nl;
          smask = (m_mode == 2) ? 64'hFFFF_FFFF : 64'hFFFF;
          if (!in_zero_skipped && m_mode != 3) begin
            for (int k = 0; k < nl; k++) begin
              a = (in_result >> (16 * k)) & smask;
              lane[k] = (lw == 64) ? lane[k] + a : (lane[k] + a) % (64'd1 << lw);
            end
          end
          if (in_zero_skipped) m_skip++;
          m_cnt++;
          if (m_cnt == m_len) begin
            new_e.sum = 0;
            for (int k = 0; k < nl; k++) new_e.sum = new_e.sum | (lane[k] << (lw * k));
            new_e.skip = m_skip;
            pend_e = new_e;
            pend = 1;
            m_cnt = 0; m_skip = 0;
            for (int k = 0; k < 4; k++) lane[k] = 0;
          end
        end
        if (stop) begin
          m_busy = 0;
          m_cnt = 0; m_skip = 0;
          for (int k = 0; k < 4; k++) lane[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_fifo_level", fifo_level, q.size());
      chk("m_overflow", overflow, m_ovf);
      chk("m_busy", busy, m_busy);
      if (q.size() > 0) begin
        chk("m_out_sum", out_sum, q[0].sum);
        chk("m_out_skip", out_skip_cnt, q[0].skip);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [1:0] m, input logic [7:0] l);
    start = 1'b1; mode = m; vec_len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic elem(input logic [63:0] r, input logic sk);
    in_valid = 1'b1; in_result = r; in_zero_skipped = sk;
    @(negedge clk);
    in_valid = 1'b0; in_zero_skipped = 1'b0;
  endtask

  task automatic expect_head(input string nm, input logic [63:0] s, input int sk);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_sum"}, out_sum, s);
      chk({nm, "_skip"}, out_skip_cnt, sk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // mode 01, length 3: one cycle of staging before the entry becomes visible
    do_start(2'b01, 8'd3);
    chk("t1_busy", busy, 1);
    repeat (3) elem(64'h0000_0000_0002_0003, 1'b0);
    chk("t1_not_yet", out_valid, 0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    expect_head("t1", 64'h0000_0006_0000_0009, 0);

    do_start(2'b10, 8'd4);
    elem(64'd5, 1'b0);
    elem(64'hFFFF, 1'b1);
    elem(64'd7, 1'b0);
    elem(64'h1234, 1'b1);
    expect_head("t2", 64'd12, 2);

    do_start(2'b00, 8'd2);
    repeat (2) elem(64'h0001_0002_0003_FFFF, 1'b0);
    expect_head("t3", 64'h0002_0004_0006_FFFE, 0);

    // five single-element vectors into a 4-deep FIFO with the consumer stalled
    do_start(2'b10, 8'd1);
    for (int i = 1; i <= 5; i++) elem(64'(i), 1'b0);
    @(negedge clk);
    chk("t4_level", fifo_level, 4);
    chk("t4_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t4_order", out_sum, i);
      @(negedge clk);
    end
    chk("t4_empty", out_valid, 0);
    out_ready = 1'b0;
    do_start(2'b10, 8'd1);
    chk("t4_ovf_clr", overflow, 0);

    do_start(2'b10, 8'd0);
    repeat (256) elem(64'd1, 1'b0);
    expect_head("t5_full", 64'd256, 0);

    do_start(2'b10, 8'd3);
    elem(64'd10, 1'b0);
    elem(64'd20, 1'b0);
    do_start(2'b10, 8'd3);
    elem(64'd1, 1'b0);
    elem(64'd2, 1'b0);
    elem(64'd3, 1'b0);
    expect_head("t5_restart", 64'd6, 0);

    do_start(2'b10, 8'd3);
    elem(64'd9, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) elem(64'd4, 1'b0);
    @(negedge clk);
    chk("t6_stop_busy", busy, 0);
    chk("t6_stop_level", fifo_level, 0);

    // two entries pending plus a partial vector, then asynchronous reset between edges
    do_start(2'b10, 8'd3);
    for (int i = 1; i <= 7; i++) elem(64'(i), 1'b0);
    @(negedge clk);
    chk("t7_level", fifo_level, 2);
    chk("t7_head", out_sum, 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_sum", out_sum, 0);
    chk("t7_rst_skip", out_skip_cnt, 0);
    chk("t7_rst_ovf", overflow, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_level", fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) elem(64'd3, 1'b0);
    @(negedge clk);
    chk("t7_idle_busy", busy, 0);
    chk("t7_idle_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_result_accumulator.md
# gpu_result_accumulator

Downstream consumer of the pipelined GPU datapath's result stream (64-bit result, valid, zero-skip flag).
- Sums consecutive products into per-lane dot-product totals of a programmable vector length, honouring the ALU precision mode.
- Buffers completed sums in a small output FIFO with valid/ready handshake, so the non-stallable pipeline can run at full rate.
- Reports per-vector zero-skip counts and a sticky overflow flag when a completed sum has to be dropped.

## Interface
Parameters:
- LEN_W, 8: vector-length field width. vec_len = 0 means 2^LEN_W elements.
- FIFO_AW, 2: FIFO address width. Depth is 2^FIFO_AW = 4.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  pulse: latch mode/vec_len, clear partial sum, clear overflow, enter RUN.
- stop  in  1  pulse: discard partial sum, enter IDLE. FIFO contents kept.
- mode  in  2  precision mode, latched on start (00 = 4×16b lanes, 01 = 2×32b, 10 = 1×64b, 11 = none).
- vec_len  in  LEN_W  elements per dot product, latched on start.
- in_valid  in  1  upstream result valid; no backpressure exists.
- in_result  in  64  upstream product word.
- in_zero_skipped  in  1  element was zero-skipped; its data is ignored.
- out_ready  in  1  consumer accepts FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_sum  out  64  FIFO head: packed lane sums.
- out_skip_cnt  out  LEN_W+1  FIFO head: zero-skipped elements in that vector.
- overflow  out  1  sticky: a completed vector was dropped because the FIFO was full.
- busy  out  1  FSM in RUN.
- fifo_level  out  FIFO_AW+1  occupied FIFO entries.

## Operation
FSM states and transitions:
- IDLE: in_valid ignored.
- IDLE → RUN on start.
- RUN → IDLE on stop.
- start in RUN restarts: partial sum discarded, new config latched.
- start and stop together: start wins.

Per-element rule in RUN (element = in_valid high and start low):
- Treat the addend as zero if in_zero_skipped = 1 or latched mode = 11.
- Otherwise add lane-wise:
  - mode 00: four 16-bit slots, in_result[16k+15:16k] added to acc lane k, modulo 2^16.
  - mode 01: in_result[15:0] to acc[31:0], in_result[31:16] to acc[63:32], each modulo 2^32.
  - mode 10: in_result[31:0] zero-extended into the 64-bit acc.
- No carry crosses lane boundaries.
- Increment skip_cnt if in_zero_skipped = 1.
- Increment elem_cnt.

Vector completion:
- When elem_cnt reaches the latched length (0 → 2^LEN_W), push {acc + addend, skip_cnt + skip} into the FIFO.
- Clear acc, skip_cnt and elem_cnt in the same edge.
- Stay in RUN; the next element starts a new vector.

FIFO behaviour:
- Pop when out_valid and out_ready are both high.
- Push when full with no simultaneous pop: entry dropped, overflow set to 1.
- Push when full with a simultaneous pop: push succeeds, level unchanged.
- Push when empty with out_ready high: the entry appears on the next cycle (no fall-through).
- overflow clears only on start or reset.

Element on a start cycle: discarded.

## Timing
Reset (rst_n low, asynchronous) forces:
- FSM to IDLE; acc, elem_cnt, skip_cnt and latched config to 0.
- FIFO pointers and fifo_level to 0.
- out_valid = 0, out_sum = 0, out_skip_cnt = 0, overflow = 0, busy = 0.
- Reset mid-vector loses the partial sum and all FIFO entries.

Cycle timing:
- busy rises the cycle after start.
- Last element sampled at edge t: out_valid, out_sum and out_skip_cnt are valid after edge t+1 if the FIFO was empty. Latency is 1 cycle.
- Throughput: 1 element per cycle. With vec_len = 1, one FIFO push per cycle.
- out_sum / out_skip_cnt hold stable while out_valid = 1 and out_ready = 0.
- fifo_level updates in the same edge as push/pop.

## Test plan
- Basic sum: start mode=01, vec_len=3; three elements in_result=64'h0000_0000_0002_0003 → one entry, out_sum=64'h0000_0006_0000_0009, out_skip_cnt=0, out_valid one cycle after the third element.
- Zero skip: mode=10, vec_len=4; results 5, skip(in_result=64'hFFFF), 7, skip(64'h1234) → out_sum=12, out_skip_cnt=2.
- Lane isolation: mode=00, vec_len=2; in_result=64'h0001_0002_0003_FFFF twice → out_sum=64'h0002_0004_0006_FFFE (lane 0 wraps, no carry into lane 1).
- Overflow and order: vec_len=1, out_ready=0, five elements 1..5 → fifo_level=4, overflow=1. Then out_ready=1 → pops 1,2,3,4 in order, 5 absent. Next start clears overflow.
- Full-length and restart: vec_len=0, 256 elements of 1 in mode 10 → out_sum=256. Separately, start again after 2 of 3 elements → partial discarded; next 3 elements give only their own sum.
- Async reset: assert rst_n low mid-vector with 2 FIFO entries pending, off a clock edge → all outputs 0 immediately. After release, in_valid is ignored until start.
